// File: rtl/i1i2_pattern_gen.sv
// i1i2_pattern_gen: emits the fixed 11-step i1/i2 pattern, each step held HOLD_CYCLES cycles.
// Define PATTERN_GEN_LOOP_EN to repeat the pattern continuously until abort or reset.
`default_nettype none

module i1i2_pattern_gen #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       i1,
  output logic       i2,
  output logic       busy,
  output logic       done,
  output logic [3:0] step
);

  localparam logic [0:0]       S_IDLE    = 1'b0;
  localparam logic [0:0]       S_EMIT    = 1'b1;
  localparam logic [3:0]       LAST_STEP = 4'd11;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             i1_q, i1_d;
  logic             i2_q, i2_d;

  // Line levels {i1,i2} for a given step; step 0 is the idle level.
  function automatic logic [1:0] step_levels(input logic [3:0] s);
    logic [1:0] lv;
    case (s)
      4'd1, 4'd5:                      lv = 2'b10;
      4'd2, 4'd6, 4'd10:               lv = 2'b11;
      4'd3, 4'd7, 4'd9, 4'd11:         lv = 2'b01;
      default:                         lv = 2'b00;
    endcase
    return lv;
  endfunction

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_EMIT;
          step_d  = 4'd1;
          cnt_d   = '0;
        end
      end
      default: begin
        if (abort) begin
          state_d = S_IDLE;
          step_d  = 4'd0;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (step_q == LAST_STEP) begin
            done_d = 1'b1;
`ifdef PATTERN_GEN_LOOP_EN
            step_d  = 4'd1;
`else
            state_d = S_IDLE;
            step_d  = 4'd0;
`endif
          end else begin
            step_d = step_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    endcase
    {i1_d, i2_d} = step_levels(step_d);
    busy_d       = (state_d == S_EMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= 4'd0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      i1_q    <= 1'b0;
      i2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
    end
  end

  assign i1   = i1_q;
  assign i2   = i2_q;
  assign busy = busy_q;
  assign done = done_q;
  assign step = step_q;

endmodule

`default_nettype wire
